red_pitaya_asg_sweep: RTL and testbench
=======================================

// Module: red_pitaya_asg_sweep
// PURPOSE
//  Frequency-sweep scheduler for one ASG channel. It steps the channel's phase increment
//  from a start value toward a stop value in fixed increments, holding each value for a
//  programmable dwell. Counts sweeps and raises a software trigger at each sweep start.
//  Sits between the ASG register bank and the channel: step_o[STEP_W-1:32] drives
//  set_step_i and step_o[31:0] drives set_step_lo_i.
// PARAMETERS
//  RSZ      14              buffer address width of the driven channel
//  STEP_W   RSZ+16+32       width of the full phase-increment word
//  TICK_DIV 125             dac_clk cycles per dwell tick (1 us at 125 MHz)
// PORTS
//  dac_clk_i        in   1       DAC clock; the only clock
//  dac_rst_i        in   1       reset, asynchronous, active-high
//  cfg_start_i      in   1       start pulse; latches all cfg_* inputs
//  cfg_stop_i       in   1       abort pulse
//  cfg_mode_i       in   1       0 = sawtooth (restart at start), 1 = triangle (ping-pong)
//  cfg_start_step_i in   STEP_W  first increment of a sweep
//  cfg_stop_step_i  in   STEP_W  last increment of a sweep; direction = stop>=start ? up : down
//  cfg_incr_i       in   STEP_W  magnitude of change per step
//  cfg_dwell_i      in   32      ticks held per step; 0 is treated as 1
//  cfg_nsweep_i     in   16      sweeps to run; 0 = run until cfg_stop_i
//  step_o           out  STEP_W  current phase increment
//  step_vld_o       out  1       1-cycle pulse when step_o changes or is reloaded
//  trig_o           out  1       1-cycle pulse at sweep start; feeds channel trig_sw_i
//  busy_o           out  1       high in RUN
//  done_o           out  1       1-cycle pulse when the sweep count completes
//  err_o            out  1       1-cycle pulse when a start is rejected
//  sweep_cnt_o      out  16      sweeps completed since last accepted start
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; tick, dwell and sweep counters 0.
//  FSM: IDLE --start ok--> RUN --count reached--> IDLE (done_o); RUN --cfg_stop_i--> IDLE.
//  Start check: incr==0 with start!=stop rejects the start. Stay in IDLE, pulse err_o, leave outputs unchanged.
//  Accepted start in cycle n. At n+1: step_o = start_step, step_vld_o = 1, trig_o = 1, busy_o = 1,
//   sweep_cnt_o = 0, direction set from the latched cfg. cfg_* is ignored until the next start.
//  Dwell: every step_o value is held exactly max(dwell,1)*TICK_DIV cycles. The tick prescaler
//   and dwell counter restart on each step_vld_o.
//  Dwell expiry when step_o != target: compute the next step at STEP_W+1 bits, with no wrap.
//   Up: next = step+incr; if next >= target, step_o = target.
//   Down: if step-target <= incr, step_o = target; else step_o = step-incr.
//   Update and step_vld_o land in the cycle after expiry.
//  Dwell expiry when step_o == target ends a sweep: sweep_cnt_o increments by 1, saturating at 16'hFFFF.
//   If nsweep != 0 and the new count == nsweep: go to IDLE, busy_o = 0, done_o pulses,
//    step_o holds its final value.
//   Otherwise, sawtooth: step_o = start_step, step_vld_o and trig_o pulse.
//   Otherwise, triangle: swap target between start and stop, reverse direction, take the next step.
//    trig_o does not pulse. Each leg counts as one sweep.
//  start==stop: each sweep is a single dwell at start_step; a sawtooth restart still pulses trig_o.
//  cfg_stop_i in RUN: IDLE next cycle; step_o held; no done_o; counters frozen.
//  cfg_stop_i in IDLE: no effect.
//  cfg_start_i in RUN: ignored. If it coincides with cfg_stop_i, stop wins.
//  Start and stop in the same cycle while IDLE: start is ignored.
//  Async reset mid-sweep: immediate return to reset values; no done_o.
// TESTING  (TICK_DIV=4 in bench)
//  T1 Sawtooth up: start=100, stop=130, incr=10, dwell=2, nsweep=2.
//     Expect step 100,110,120,130, each held 8 cycles, then 100..130 again.
//     trig_o pulses twice; done_o after 64 cycles; sweep_cnt_o=2.
//  T2 Overshoot clamp: start=0, stop=25, incr=10, dwell=1, nsweep=1.
//     Expect step 0,10,20,25 (clamped), each held 4 cycles, then done_o.
//  T3 Triangle down-start: start=50, stop=20, incr=15, dwell=0, nsweep=3.
//     Expect 50,35,20,35,50,35,20, each held 4 cycles (dwell 0 acts as 1).
//     trig_o pulses once; sweep_cnt_o=3.
//  T4 Abort: nsweep=0; pulse cfg_stop_i mid-dwell.
//     Expect busy_o low the next cycle, step_o frozen, no done_o. A restart then works normally.
//  T5 Reject and collisions: incr=0 with start=5, stop=9 -> err_o pulse, busy_o stays 0.
//     cfg_start_i during RUN -> ignored. Start together with stop -> no start.
//  T6 Full-width boundary: start=2^STEP_W-20, stop=2^STEP_W-1, incr=15.
//     Expect steps start, start+15, then stop; no wrap to small values.

Source files
------------

// File: rtl/red_pitaya_asg_sweep.sv
// Frequency-sweep scheduler for one ASG channel: walks the phase increment from a
// start value to a stop value in fixed steps, holding each value for a programmable dwell.
module red_pitaya_asg_sweep #(
  parameter int RSZ      = 14,
  parameter int STEP_W   = RSZ + 16 + 32,
  parameter int TICK_DIV = 125
) (
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              cfg_start_i,
  input  logic              cfg_stop_i,
  input  logic              cfg_mode_i,
  input  logic [STEP_W-1:0] cfg_start_step_i,
  input  logic [STEP_W-1:0] cfg_stop_step_i,
  input  logic [STEP_W-1:0] cfg_incr_i,
  input  logic [31:0]       cfg_dwell_i,
  input  logic [15:0]       cfg_nsweep_i,
  output logic [STEP_W-1:0] step_o,
  output logic              step_vld_o,
  output logic              trig_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [15:0]       sweep_cnt_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t r_state, w_state_nxt;

  logic [STEP_W-1:0] r_step, r_start, r_stop, r_incr;
  logic [31:0]       r_dwell, r_dwell_cnt;
  logic [15:0]       r_nsweep, r_sweep_cnt;
  logic [TW-1:0]     r_tick;
  logic              r_mode, r_up, r_leg;
  logic              r_vld, r_trig, r_done, r_err;

  // One step toward tgt, computed one bit wider so a full-scale step clamps instead of wrapping.
  function automatic logic [STEP_W-1:0] f_next(input logic [STEP_W-1:0] step,
                                               input logic [STEP_W-1:0] tgt,
                                               input logic [STEP_W-1:0] inc,
                                               input logic              up);
    logic [STEP_W:0] sum;
    logic [STEP_W:0] diff;
    sum  = {1'b0, step} + {1'b0, inc};
    diff = {1'b0, step} - {1'b0, tgt};
    if (up) f_next = (sum >= {1'b0, tgt}) ? tgt : sum[STEP_W-1:0];
    else    f_next = (diff <= {1'b0, inc}) ? tgt : step - inc;
  endfunction

  logic              w_idle, w_run, w_start_req, w_cfg_bad, w_accept, w_reject;
  logic              w_tick_last, w_expire, w_at_tgt, w_sweep_end, w_finish;
  logic [31:0]       w_dwell_m1;
  logic [15:0]       w_cnt_inc;
  logic [STEP_W-1:0] w_target, w_target_sw;

  assign w_idle      = (r_state == S_IDLE);
  assign w_run       = (r_state == S_RUN);
  assign w_start_req = cfg_start_i & ~cfg_stop_i & w_idle;
  assign w_cfg_bad   = (cfg_incr_i == '0) && (cfg_start_step_i != cfg_stop_step_i);
  assign w_accept    = w_start_req & ~w_cfg_bad;
  assign w_reject    = w_start_req & w_cfg_bad;

  // r_leg=0 heads toward stop, r_leg=1 heads back toward start (triangle only).
  assign w_target    = r_leg ? r_start : r_stop;
  assign w_target_sw = r_leg ? r_stop  : r_start;
  assign w_dwell_m1  = (r_dwell == 32'd0) ? 32'd0 : r_dwell - 32'd1;
  assign w_tick_last = (r_tick == TW'(TICK_DIV - 1));
  assign w_expire    = w_run & ~cfg_stop_i & w_tick_last & (r_dwell_cnt == w_dwell_m1);
  assign w_at_tgt    = (r_step == w_target);
  assign w_sweep_end = w_expire & w_at_tgt;
  assign w_cnt_inc   = (r_sweep_cnt == 16'hFFFF) ? r_sweep_cnt : r_sweep_cnt + 16'd1;
  assign w_finish    = w_sweep_end && (r_nsweep != 16'd0) && (w_cnt_inc == r_nsweep);

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (cfg_stop_i || w_finish) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      r_step      <= '0;
      r_start     <= '0;
      r_stop      <= '0;
      r_incr      <= '0;
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
      r_nsweep    <= '0;
      r_sweep_cnt <= '0;
      r_tick      <= '0;
      r_mode      <= 1'b0;
      r_up        <= 1'b0;
      r_leg       <= 1'b0;
      r_vld       <= 1'b0;
      r_trig      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_trig <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        r_start     <= cfg_start_step_i;
        r_stop      <= cfg_stop_step_i;
        r_incr      <= cfg_incr_i;
        r_dwell     <= cfg_dwell_i;
        r_nsweep    <= cfg_nsweep_i;
        r_mode      <= cfg_mode_i;
        r_up        <= (cfg_stop_step_i >= cfg_start_step_i);
        r_leg       <= 1'b0;
        r_step      <= cfg_start_step_i;
        r_sweep_cnt <= '0;
        r_tick      <= '0;
        r_dwell_cnt <= '0;
        r_vld       <= 1'b1;
        r_trig      <= 1'b1;
      end else if (w_reject) begin
        r_err <= 1'b1;
      end else if (w_run && !cfg_stop_i) begin
        if (w_expire) begin
          r_tick      <= '0;
          r_dwell_cnt <= '0;
          if (!w_at_tgt) begin
            r_step <= f_next(r_step, w_target, r_incr, r_up);
            r_vld  <= 1'b1;
          end else begin
            r_sweep_cnt <= w_cnt_inc;
            if (w_finish) begin
              r_done <= 1'b1;
            end else if (!r_mode) begin
              r_step <= r_start;
              r_vld  <= 1'b1;
              r_trig <= 1'b1;
            end else begin
              r_leg  <= ~r_leg;
              r_up   <= ~r_up;
              r_step <= f_next(r_step, w_target_sw, r_incr, ~r_up);
              r_vld  <= 1'b1;
            end
          end
        end else if (w_tick_last) begin
          r_tick      <= '0;
          r_dwell_cnt <= r_dwell_cnt + 32'd1;
        end else begin
          r_tick <= r_tick + TW'(1);
        end
      end
    end
  end

  assign step_o      = r_step;
  assign step_vld_o  = r_vld;
  assign trig_o      = r_trig;
  assign busy_o      = w_run;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign sweep_cnt_o = r_sweep_cnt;

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Directed bench for red_pitaya_asg_sweep with a short tick prescaler (TICK_DIV=4).
module tb_red_pitaya_asg_sweep;
  localparam int RSZ      = 14;
  localparam int STEP_W   = RSZ + 16 + 32;
  localparam int TICK_DIV = 4;
  localparam logic [STEP_W-1:0] MAXV = '1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0, cfg_stop = 1'b0, cfg_mode = 1'b0;
  logic [STEP_W-1:0] cfg_start_step = '0, cfg_stop_step = '0, cfg_incr = '0;
  logic [31:0]       cfg_dwell = '0;
  logic [15:0]       cfg_nsweep = '0;
  logic [STEP_W-1:0] step;
  logic              step_vld, trig, busy, done, err;
  logic [15:0]       sweep_cnt;

  always #5 clk = ~clk;

  red_pitaya_asg_sweep #(.RSZ(RSZ), .STEP_W(STEP_W), .TICK_DIV(TICK_DIV)) dut (
    .dac_clk_i(clk), .dac_rst_i(rst),
    .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop), .cfg_mode_i(cfg_mode),
    .cfg_start_step_i(cfg_start_step), .cfg_stop_step_i(cfg_stop_step),
    .cfg_incr_i(cfg_incr), .cfg_dwell_i(cfg_dwell), .cfg_nsweep_i(cfg_nsweep),
    .step_o(step), .step_vld_o(step_vld), .trig_o(trig), .busy_o(busy),
    .done_o(done), .err_o(err), .sweep_cnt_o(sweep_cnt)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] seen[$];
  int          holds[$];
  logic [63:0] exp_q[$];
  int          ntrig;
  int          done_at;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic mode, input logic [STEP_W-1:0] s, input logic [STEP_W-1:0] e,
                         input logic [STEP_W-1:0] inc, input logic [31:0] dw, input logic [15:0] ns);
    cfg_mode = mode; cfg_start_step = s; cfg_stop_step = e;
    cfg_incr = inc; cfg_dwell = dw; cfg_nsweep = ns;
  endtask

  // Pulse start and check the first-cycle outputs.
  task automatic start_run(input string tag);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk({tag, "_step0"}, 64'(step), 64'(cfg_start_step));
    chk({tag, "_vld0"}, 64'(step_vld), 64'd1);
    chk({tag, "_trig0"}, 64'(trig), 64'd1);
    chk({tag, "_busy0"}, 64'(busy), 64'd1);
    chk({tag, "_cnt0"}, 64'(sweep_cnt), 64'd0);
    seen.delete();
    holds.delete();
    seen.push_back(64'(step));
    ntrig = 1;
  endtask

  // Record each step value and its hold length until done_o or the cycle budget runs out.
  task automatic watch(input string tag, input int maxc, input int exp_done);
    int h;
    int cyc;
    h = 1; cyc = 0; done_at = -1;
    while (cyc < maxc) begin
      tick();
      cyc++;
      if (trig) ntrig++;
      if (done) begin
        holds.push_back(h);
        done_at = cyc;
        break;
      end
      if (step_vld) begin
        holds.push_back(h);
        seen.push_back(64'(step));
        h = 1;
      end else begin
        h++;
      end
    end
    chk({tag, "_done_at"}, 64'(done_at), 64'(exp_done));
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_seen(input string tag, input int hold);
    chk({tag, "_nsteps"}, 64'(seen.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++)
      chk($sformatf("%s_step%0d", tag, i), seen[i], exp_q[i]);
    for (int i = 0; i < holds.size(); i++)
      chk($sformatf("%s_hold%0d", tag, i), 64'(holds[i]), 64'(hold));
  endtask

  initial begin
    logic any_done;

    // Reset state
    tick(); tick();
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({step_vld, trig, done, err}), 64'd0);
    chk("rst_cnt", 64'(sweep_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // T1 sawtooth up
    set_cfg(1'b0, 100, 130, 10, 2, 2);
    start_run("t1");
    watch("t1", 100, 64);
    exp_q = '{100, 110, 120, 130, 100, 110, 120, 130};
    chk_seen("t1", 8);
    chk("t1_trig", 64'(ntrig), 64'd2);
    chk("t1_cnt", 64'(sweep_cnt), 64'd2);
    chk("t1_final", 64'(step), 64'd130);

    // T2 overshoot clamp
    set_cfg(1'b0, 0, 25, 10, 1, 1);
    start_run("t2");
    watch("t2", 40, 16);
    exp_q = '{0, 10, 20, 25};
    chk_seen("t2", 4);
    chk("t2_cnt", 64'(sweep_cnt), 64'd1);

    // T3 triangle starting downward, dwell 0 acts as 1
    set_cfg(1'b1, 50, 20, 15, 0, 3);
    start_run("t3");
    watch("t3", 60, 28);
    exp_q = '{50, 35, 20, 35, 50, 35, 20};
    chk_seen("t3", 4);
    chk("t3_trig", 64'(ntrig), 64'd1);
    chk("t3_cnt", 64'(sweep_cnt), 64'd3);

    // T4 abort mid-dwell
    set_cfg(1'b0, 0, 1000, 1, 1, 0);
    start_run("t4");
    repeat (10) tick();
    chk("t4_mid_step", 64'(step), 64'd2);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    chk("t4_stop_busy", 64'(busy), 64'd0);
    chk("t4_stop_step", 64'(step), 64'd2);
    any_done = done;
    repeat (6) begin
      tick();
      any_done |= done | step_vld;
    end
    chk("t4_no_done", 64'(any_done), 64'd0);
    chk("t4_frozen_step", 64'(step), 64'd2);
    chk("t4_frozen_cnt", 64'(sweep_cnt), 64'd0);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    chk("t4_idle_stop", 64'({busy, err, step_vld}), 64'd0);
    chk("t4_idle_stop_step", 64'(step), 64'd2);
    set_cfg(1'b0, 7, 9, 1, 1, 1);
    start_run("t4r");
    watch("t4r", 30, 12);
    exp_q = '{7, 8, 9};
    chk_seen("t4r", 4);
    chk("t4r_cnt", 64'(sweep_cnt), 64'd1);

    // T5 rejected start and collisions
    set_cfg(1'b0, 5, 9, 0, 1, 0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_rej_busy", 64'(busy), 64'd0);
    chk("t5_rej_step", 64'(step), 64'd9);
    chk("t5_rej_trig", 64'(trig), 64'd0);
    tick();
    chk("t5_err_pulse", 64'(err), 64'd0);
    set_cfg(1'b0, 5, 9, 1, 1, 0);
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    chk("t5_ss_idle", 64'({busy, trig, step_vld, err}), 64'd0);
    chk("t5_ss_step", 64'(step), 64'd9);
    start_run("t5");
    set_cfg(1'b0, 100, 200, 3, 5, 2);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("t5_run_start_trig", 64'({trig, step_vld}), 64'd0);
    chk("t5_run_start_step", 64'(step), 64'd5);
    chk("t5_run_start_busy", 64'(busy), 64'd1);
    tick(); tick();
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    chk("t5_stop_wins", 64'({busy, trig, step_vld, done}), 64'd0);
    chk("t5_stop_wins_step", 64'(step), 64'd5);

    // T6 full-width boundary
    set_cfg(1'b0, MAXV - 62'd19, MAXV, 15, 1, 1);
    start_run("t6");
    watch("t6", 30, 12);
    exp_q = '{64'(MAXV - 62'd19), 64'(MAXV - 62'd4), 64'(MAXV)};
    chk_seen("t6", 4);

    // Async reset mid-sweep, asserted away from any clock edge
    set_cfg(1'b0, 100, 130, 10, 2, 0);
    start_run("ar");
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("ar_step", 64'(step), 64'd0);
    chk("ar_busy", 64'({busy, done, step_vld, trig}), 64'd0);
    chk("ar_cnt", 64'(sweep_cnt), 64'd0);
    tick();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
